// File: rtl/mem_rd_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// main-memory line reader.
package mem_rd_pkg;

  localparam int MEM_BYTES   = 32'h8000;
  localparam int MEM_ADDR_W  = $clog2(MEM_BYTES);
  localparam int LINE_BYTES  = 32;
  localparam int OFS_W       = $clog2(LINE_BYTES);
  localparam int LINE_W      = MEM_ADDR_W - OFS_W;
  localparam int LINE_DATA_W = LINE_BYTES * 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_REQ    = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_STREAM = 3'd3;
  localparam state_t ST_FIN    = 3'd4;

  // Byte address layout: row [14:12], line-in-row [11:5], col [4:2], bank [1:0].
  function automatic logic [2:0] addr_row(input logic [MEM_ADDR_W-1:0] a);
    return a[14:12];
  endfunction

  function automatic logic [6:0] addr_lir(input logic [MEM_ADDR_W-1:0] a);
    return a[11:5];
  endfunction

  function automatic logic [2:0] addr_col(input logic [MEM_ADDR_W-1:0] a);
    return a[4:2];
  endfunction

  function automatic logic [1:0] addr_bank(input logic [MEM_ADDR_W-1:0] a);
    return a[1:0];
  endfunction

  function automatic logic [LINE_W-1:0] addr_line(input logic [MEM_ADDR_W-1:0] a);
    return a[MEM_ADDR_W-1:OFS_W];
  endfunction

endpackage

// File: rtl/mem_line_reader_buf.sv
// Line buffer: holds one fetched 256-bit memory line and selects one byte
// by its in-line offset {col, bank}.
module mem_line_reader_buf
  import mem_rd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [LINE_DATA_W-1:0] line_in,
  input  logic [OFS_W-1:0]       sel,
  output logic [7:0]             byte_out
);

  logic [LINE_DATA_W-1:0] line_q;

  // Cleared on reset so a read landing mid-reset never leaks into a later transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= line_in;
    end
  end

  assign byte_out = line_q[{sel, 3'b000} +: 8];

endmodule

// File: rtl/mem_line_reader.sv
// Read-side engine: fetches 32-byte lines from main memory and streams a
// byte range out over valid/ready, one byte per cycle.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   IDLE      | waiting for start
//   REQ       | mem_req high for current line, waiting for mem_gnt
//   WAIT      | granted, waiting for mem_rd_valid
//   STREAM    | presenting buffered bytes to the consumer
//   FIN       | one-cycle done pulse
module mem_line_reader
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         start_addr,
  input  logic [CNT_W-1:0]          byte_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_req,
  output logic [ADDR_W-OFS_W-1:0]   mem_line,
  input  logic                      mem_gnt,
  input  logic                      mem_rd_valid,
  input  logic [LINE_DATA_W-1:0]    mem_rd_data,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic                      out_last,
  input  logic                      out_ready
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [7:0]        buf_byte;
  logic              buf_load;
  logic              xfer;
  logic              last_in_line;
  logic              last_byte;

  assign xfer         = out_valid && out_ready;
  assign last_in_line = (addr[OFS_W-1:0] == OFS_W'(LINE_BYTES - 1));
  assign last_byte    = (remaining == CNT_W'(1));
  assign buf_load     = (state == ST_WAIT) && mem_rd_valid;

  // addr wraps naturally at 2^ADDR_W, so line 0 follows the top line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= byte_cnt;
            state     <= (byte_cnt == '0) ? ST_FIN : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rd_valid) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (xfer) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (last_byte) begin
              state <= ST_FIN;
            end else if (last_in_line) begin
              state <= ST_REQ;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  mem_line_reader_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .line_in  (mem_rd_data),
    .sel      (addr[OFS_W-1:0]),
    .byte_out (buf_byte)
  );

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign mem_req   = (state == ST_REQ);
  assign mem_line  = mem_req ? addr[ADDR_W-1:OFS_W] : '0;
  assign out_valid = (state == ST_STREAM);
  assign out_data  = out_valid ? buf_byte : 8'h00;
  assign out_last  = out_valid && last_byte;

endmodule

// File: tb/tb_mem_line_reader.sv
// Bench for mem_line_reader: memory responder plus byte-stream reference
// model computed from plain address arithmetic over a byte array.
`timescale 1ns/1ps
module tb_mem_line_reader;

  localparam int AW = 15;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] byte_cnt;
  logic         busy;
  logic         done;
  logic         mem_req;
  logic [9:0]   mem_line;
  logic         mem_gnt;
  logic         mem_rd_valid;
  logic [255:0] mem_rd_data;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready;

  always #5 clk = ~clk;

  mem_line_reader #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .byte_cnt     (byte_cnt),
    .busy         (busy),
    .done         (done),
    .mem_req      (mem_req),
    .mem_line     (mem_line),
    .mem_gnt      (mem_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:32767];
  int unsigned req_q[$];
  int          gnt_dly = 0;
  int          rd_dly  = 0;

  int          rsp_phase;
  int          rsp_cnt;
  int unsigned rsp_line;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: grants after gnt_dly cycles, returns data rd_dly+1 cycles later.
  initial begin : responder
    mem_gnt      = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    rsp_phase    = 0;
    rsp_cnt      = 0;
    rsp_line     = 0;
    forever begin
      @(negedge clk);
      mem_gnt      = 1'b0;
      mem_rd_valid = 1'b0;
      if (rsp_phase == 0 && mem_req === 1'b1) begin
        rsp_line = 32'(mem_line);
        req_q.push_back(rsp_line);
        rsp_cnt   = gnt_dly;
        rsp_phase = 1;
      end
      if (rsp_phase == 1) begin
        if (rsp_cnt == 0) begin
          mem_gnt   = 1'b1;
          rsp_cnt   = rd_dly;
          rsp_phase = 2;
        end else begin
          rsp_cnt--;
        end
      end else if (rsp_phase == 2) begin
        if (rsp_cnt == 0) begin
          for (int b = 0; b < 32; b++) mem_rd_data[8*b +: 8] = mem[15'(rsp_line * 32 + b)];
          mem_rd_valid = 1'b1;
          rsp_phase    = 0;
        end else begin
          rsp_cnt--;
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_xfer(input int unsigned a, input int unsigned n, input bit rnd_ready, input bit poke);
    int unsigned exp_lines[$];
    int unsigned p;
    int unsigned base;
    int unsigned idx;
    int          cyc;
    bit          expect_req;

    base       = req_q.size();
    start      = 1'b1;
    start_addr = AW'(a);
    byte_cnt   = CW'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    if (n == 0) begin
      chk("zero_done", 64'(done), 64'(1));
      chk("zero_no_req_now", 64'(mem_req), 64'(0));
      @(negedge clk);
      chk("zero_clear", 64'({busy, done}), 64'(0));
      chk("zero_no_req", 64'(req_q.size() - base), 64'(0));
      return;
    end
    chk("req_after_start", 64'({mem_req, mem_line}), 64'({1'b1, 10'((a % 32768) / 32)}));

    idx        = 0;
    cyc        = 0;
    expect_req = 1'b0;
    while (idx < n && cyc < 3000) begin
      if (expect_req) chk("req_reassert", 64'(mem_req), 64'(1));
      expect_req = 1'b0;
      out_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = poke && ($urandom_range(0, 5) == 0);
      start_addr = AW'($urandom);
      byte_cnt   = CW'($urandom);
      chk("busy_hold", 64'(busy), 64'(1));
      if (out_valid === 1'b1) begin
        chk("out_data", 64'(out_data), 64'(mem[15'((a + idx) % 32768)]));
        if (out_ready) begin
          chk("out_last", 64'(out_last), 64'(idx == n - 1));
          if (((a + idx) % 32) == 31 && idx < n - 1) expect_req = 1'b1;
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (idx < n) chk("byte_timeout", 64'(idx), 64'(n));
    chk("done_pulse", 64'({done, busy, out_valid}), 64'(3'b110));
    @(negedge clk);
    chk("done_clear", 64'({done, busy}), 64'(0));

    for (int i = 0; i < int'(n); i++) begin
      p = (a + i) % 32768;
      if (i == 0 || p % 32 == 0) exp_lines.push_back(p / 32);
    end
    chk("line_count", 64'(req_q.size() - base), 64'(exp_lines.size()));
    for (int k = 0; k < exp_lines.size(); k++) begin
      if (base + k < req_q.size()) chk("line_addr", 64'(req_q[base + k]), 64'(exp_lines[k]));
    end
  endtask

  int w;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    byte_cnt   = '0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, mem_req, mem_line, out_valid, out_data, out_last}), 64'(0));
    rst_n = 1'b1;

    // aligned, unaligned crossing, address wrap
    run_xfer(32'h0000, 32, 1'b0, 1'b0);
    run_xfer(32'h001E, 4, 1'b0, 1'b0);
    run_xfer(32'h7FFE, 4, 1'b0, 1'b0);

    // backpressure with slow memory and ignored starts
    gnt_dly = 3;
    rd_dly  = 4;
    run_xfer($urandom_range(0, 32767), 70, 1'b1, 1'b1);
    run_xfer(32'h7FF0, 40, 1'b1, 1'b1);

    gnt_dly = 0;
    rd_dly  = 0;
    run_xfer(32'h1234, 0, 1'b0, 1'b0);

    // reset in the middle of a 64-byte stream
    start      = 1'b1;
    start_addr = 15'h0100;
    byte_cnt   = 16'd64;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("mid_stream_reached", 64'(out_valid), 64'(1));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", 64'({busy, done, mem_req, mem_line, out_valid, out_data, out_last}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(32'h0240, 8, 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      gnt_dly = $urandom_range(0, 3);
      rd_dly  = $urandom_range(0, 4);
      run_xfer($urandom_range(0, 32767), $urandom_range(1, 100), 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
